// File: rtl/conv_bias_sequencer_pkg.sv
// Shared fixed-point constants and sequencer state type for the conv2d layer tail.
package conv_bias_sequencer_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAC_BITS = 7;
  localparam int          Q17_MAX   = 127;
  localparam int          Q17_MIN   = -128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bias_add_sat.sv
// Combinational bias add, floor requantise, optional ReLU and Q1.7 saturation.
module bias_add_sat #(
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned FRAC_BITS = conv_bias_sequencer_pkg::FRAC_BITS,
  parameter bit          RELU_EN   = 1'b0
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [7:0]       bias,
  output logic [7:0]       result
);
  import conv_bias_sequencer_pkg::*;

  localparam int unsigned SUM_W = ACC_W + 1;

  logic signed [SUM_W-1:0] acc_x;
  logic signed [SUM_W-1:0] bias_x;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] q;
  logic signed [SUM_W-1:0] clip;

  // Bias is Q1.7, accumulator is Q.14: align the bias before adding.
  always_comb begin
    acc_x  = SUM_W'($signed(acc));
    bias_x = SUM_W'($signed(bias)) <<< FRAC_BITS;
    sum    = acc_x + bias_x;
    q      = sum >>> FRAC_BITS;
    clip   = q;
    if (RELU_EN && q[SUM_W-1]) begin
      clip = '0;
    end
    if (clip > SUM_W'(Q17_MAX)) begin
      clip = SUM_W'(Q17_MAX);
    end else if (clip < SUM_W'(Q17_MIN)) begin
      clip = SUM_W'(Q17_MIN);
    end
  end

  assign result = DATA_W'(clip);

endmodule

// File: rtl/conv_bias_sequencer.sv
// Frame sequencer for the per-channel bias-add/requantise tail of a conv2d layer.
module conv_bias_sequencer #(
  parameter int unsigned NUM_CH    = 64,
  parameter int unsigned NUM_PIX   = 64,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned FRAC_BITS = conv_bias_sequencer_pkg::FRAC_BITS,
  parameter bit          RELU_EN   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [ACC_W-1:0] acc_data,
  output logic [15:0]      rom_row,
  output logic [15:0]      rom_col,
  input  logic [7:0]       rom_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [15:0]      out_ch,
  output logic             out_last
);
  import conv_bias_sequencer_pkg::*;

  localparam int unsigned CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
  localparam int unsigned PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  state_t             state;
  logic [CH_W-1:0]    ch_cnt;
  logic [PIX_W-1:0]   pix_cnt;
  logic [DATA_W-1:0]  sat_data;
  logic               accept;
  logic               consume;
  logic               last_ch;
  logic               last_pix;

  bias_add_sat #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS),
    .RELU_EN   (RELU_EN)
  ) u_bias_add_sat (
    .acc    (acc_data),
    .bias   (rom_data),
    .result (sat_data)
  );

  // Single output register: a new word may enter only if the slot is free or draining now.
  assign acc_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept    = acc_valid && acc_ready;
  assign consume   = out_valid && out_ready;
  assign last_ch   = (ch_cnt == CH_W'(NUM_CH - 1));
  assign last_pix  = (pix_cnt == PIX_W'(NUM_PIX - 1));
  assign busy      = (state != IDLE);
  assign rom_row   = 16'(ch_cnt);
  assign rom_col   = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            ch_cnt  <= '0;
            pix_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sat_data;
            out_ch    <= 16'(ch_cnt);
            out_last  <= last_ch && last_pix;
            if (last_ch) begin
              ch_cnt  <= '0;
              pix_cnt <= last_pix ? '0 : pix_cnt + PIX_W'(1);
            end else begin
              ch_cnt  <= ch_cnt + CH_W'(1);
            end
            if (last_ch && last_pix) begin
              state <= DRAIN;
            end
          end else if (consume) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (consume) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
            ch_cnt    <= '0;
            pix_cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bias_sequencer.sv
// Randomised bench: three sequencers (64ch, 64ch+ReLU, 4ch) against a frame-level model.
module tb_conv_bias_sequencer;

  localparam int ACC_W = 24;
  localparam int NPIX  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic acc_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [ACC_W-1:0] acc_data = '0;

  logic        busy_w[3], done_w[3], acc_ready_w[3], out_valid_w[3], out_last_w[3];
  logic [15:0] rom_row_w[3], rom_col_w[3], out_ch_w[3];
  logic [7:0]  rom_data_w[3], out_data_w[3];
  logic signed [7:0] rom[64];

  int checks = 0;
  int failures = 0;

  // Model state per DUT: 0 idle, 1 running, 2 draining; cnt = accepts this frame.
  int   phase[3], cnt[3], ed[3], ec[3], last_idx[3];
  logic ev[3], el[3], edn[3], ar_exp[3], just_acc[3];

  always #5 clk = ~clk;

  assign rom_data_w[0] = rom[rom_row_w[0][5:0]];
  assign rom_data_w[1] = rom[rom_row_w[1][5:0]];
  assign rom_data_w[2] = rom[rom_row_w[2][5:0]];

  conv_bias_sequencer #(.NUM_CH(64), .NUM_PIX(NPIX), .ACC_W(ACC_W), .FRAC_BITS(7), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]),
    .acc_valid(acc_valid), .acc_ready(acc_ready_w[0]), .acc_data(acc_data),
    .rom_row(rom_row_w[0]), .rom_col(rom_col_w[0]), .rom_data(rom_data_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_ch(out_ch_w[0]), .out_last(out_last_w[0]));

  conv_bias_sequencer #(.NUM_CH(64), .NUM_PIX(NPIX), .ACC_W(ACC_W), .FRAC_BITS(7), .RELU_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_w[1]), .done(done_w[1]),
    .acc_valid(acc_valid), .acc_ready(acc_ready_w[1]), .acc_data(acc_data),
    .rom_row(rom_row_w[1]), .rom_col(rom_col_w[1]), .rom_data(rom_data_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_ch(out_ch_w[1]), .out_last(out_last_w[1]));

  conv_bias_sequencer #(.NUM_CH(4), .NUM_PIX(NPIX), .ACC_W(ACC_W), .FRAC_BITS(7), .RELU_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_w[2]), .done(done_w[2]),
    .acc_valid(acc_valid), .acc_ready(acc_ready_w[2]), .acc_data(acc_data),
    .rom_row(rom_row_w[2]), .rom_col(rom_col_w[2]), .rom_data(rom_data_w[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_data(out_data_w[2]),
    .out_ch(out_ch_w[2]), .out_last(out_last_w[2]));

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nch(input int k);
    return (k == 2) ? 4 : 64;
  endfunction

  // Real-valued meaning: floor((acc/2^14 + bias/2^7) * 2^7), ReLU, clamp.
  function automatic int ref_val(input int acc, input int bias, input bit relu);
    int s;
    int q;
    s = acc + bias * 128;
    if (s >= 0) q = s / 128;
    else        q = -((-s + 127) / 128);
    if (relu && q < 0) q = 0;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      phase[k] = 0; cnt[k] = 0; ev[k] = 1'b0; el[k] = 1'b0; edn[k] = 1'b0;
      ed[k] = 0; ec[k] = 0; just_acc[k] = 1'b0; last_idx[k] = -1;
    end
  endtask

  // Called just after a falling edge; leaves time at the next falling edge.
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; acc_valid = 1'b0; out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_busy[%0d]", k), 32'(busy_w[k]), 0);
      check($sformatf("rst_done[%0d]", k), 32'(done_w[k]), 0);
      check($sformatf("rst_acc_ready[%0d]", k), 32'(acc_ready_w[k]), 0);
      check($sformatf("rst_out_valid[%0d]", k), 32'(out_valid_w[k]), 0);
      check($sformatf("rst_out_data[%0d]", k), 32'(out_data_w[k]), 0);
      check($sformatf("rst_out_ch[%0d]", k), 32'(out_ch_w[k]), 0);
      check($sformatf("rst_out_last[%0d]", k), 32'(out_last_w[k]), 0);
      check($sformatf("rst_rom_row[%0d]", k), 32'(rom_row_w[k]), 0);
      check($sformatf("rom_col[%0d]", k), 32'(rom_col_w[k]), 0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle(input bit st, input bit av, input logic [ACC_W-1:0] ad, input bit ordy);
    int a;
    int consume;
    start = st; acc_valid = av; acc_data = ad; out_ready = ordy;
    a = $signed(ad);
    #1;
    for (int k = 0; k < 3; k++) begin
      ar_exp[k] = (phase[k] == 1) && (!ev[k] || ordy);
      check($sformatf("acc_ready[%0d]", k), 32'(acc_ready_w[k]), 32'(ar_exp[k]));
      check($sformatf("rom_row[%0d]", k), 32'(rom_row_w[k]), cnt[k] % nch(k));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      consume = int'(ev[k] && ordy);
      edn[k] = 1'b0;
      just_acc[k] = 1'b0;
      case (phase[k])
        0: if (st) begin phase[k] = 1; cnt[k] = 0; end
        1: begin
          if (av && ar_exp[k]) begin
            ev[k] = 1'b1;
            ed[k] = ref_val(a, int'(rom[cnt[k] % nch(k)]), k == 1);
            ec[k] = cnt[k] % nch(k);
            el[k] = (cnt[k] == nch(k) * NPIX - 1);
            just_acc[k] = 1'b1;
            last_idx[k] = cnt[k];
            if (el[k]) phase[k] = 2;
            cnt[k]++;
          end else if (consume != 0) begin
            ev[k] = 1'b0;
          end
        end
        default: if (consume != 0) begin
          ev[k] = 1'b0; phase[k] = 0; cnt[k] = 0; edn[k] = 1'b1;
        end
      endcase
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out_valid[%0d]", k), 32'(out_valid_w[k]), 32'(ev[k]));
      check($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(phase[k] != 0));
      check($sformatf("done[%0d]", k), 32'(done_w[k]), 32'(edn[k]));
      if (ev[k]) begin
        check($sformatf("out_data[%0d]", k), 32'($signed(out_data_w[k])), ed[k]);
        check($sformatf("out_ch[%0d]", k), 32'(out_ch_w[k]), ec[k]);
        check($sformatf("out_last[%0d]", k), 32'(out_last_w[k]), 32'(el[k]));
      end
    end
  endtask

  function automatic logic [ACC_W-1:0] rand_acc();
    if ($urandom_range(0, 1) == 1) return ACC_W'($urandom);
    return ACC_W'(int'($urandom_range(0, 65535)) - 32768);
  endfunction

  function automatic logic [ACC_W-1:0] directed_acc(input int idx);
    case (idx)
      0:       return ACC_W'(0);
      8:       return ACC_W'(-1);
      39:      return ACC_W'(12800);
      64:      return ACC_W'(-16384);
      72:      return ACC_W'(127);
      default: return rand_acc();
    endcase
  endfunction

  initial begin
    int guard;
    int n_out;
    int n_done;
    bit ordy;
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    rom[0] = -8'sd39; rom[8] = 8'sd0; rom[39] = 8'sd68;
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed arithmetic corners inside one full 64x2 frame with backpressure.
    cycle(1'b1, 1'b0, '0, 1'b1);
    guard = 0;
    while ((phase[0] != 0 || ev[0]) && guard < 3000) begin
      cycle(guard == 50, $urandom_range(0, 3) != 0, directed_acc(cnt[0]), $urandom_range(0, 2) != 0);
      if (just_acc[0]) begin
        case (last_idx[0])
          0:  begin
                check("ch0_bias_only", 32'($signed(out_data_w[0])), -39);
                check("ch0_relu", 32'($signed(out_data_w[1])), 0);
              end
          8:  check("floor_neg1", 32'($signed(out_data_w[0])), -1);
          39: check("sat_pos", 32'($signed(out_data_w[0])), 127);
          64: check("sat_neg", 32'($signed(out_data_w[0])), -128);
          72: check("floor_127", 32'($signed(out_data_w[0])), 0);
          default: ;
        endcase
      end
      guard++;
    end
    check("frame64_timeout", 32'(guard >= 3000), 0);

    // Small 4x2 frame: count outputs and done pulses under random stalls.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b1);
    n_out = 0; n_done = 0; guard = 0;
    while ((phase[2] != 0 || ev[2]) && guard < 500) begin
      ordy = $urandom_range(0, 1) == 1;
      if (out_valid_w[2] && ordy) n_out++;
      cycle(1'b0, $urandom_range(0, 2) != 0, rand_acc(), ordy);
      if (done_w[2]) n_done++;
      guard++;
    end
    check("frame4_timeout", 32'(guard >= 500), 0);
    check("frame4_outputs", n_out, 8);
    check("frame4_done_pulses", n_done, 1);

    // Full throughput, start pulse while running must not restart the frame.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 40; i++) cycle(i == 20, 1'b1, rand_acc(), 1'b1);
    check("throughput_cnt", cnt[0], 40);
    check("throughput_ch", 32'(out_ch_w[0]), 39);

    // Reset mid-frame then restart from channel 0.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rand_acc(), 1'b1);
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, rand_acc(), 1'b0);
    check("restart_ch0", 32'(out_ch_w[0]), 0);

    // Random soak including random start pulses.
    do_reset();
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rand_acc(), $urandom_range(0, 3) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
